// File: rtl/screen_raster_unshifter_pkg.sv
// Shared definitions for the screen-space raster unshifter and its
// companion origin-shift stage: screen geometry, the signed Q11.10
// coordinate type, the screen-centre constants and the scan FSM states.
package screen_raster_unshifter_pkg;

    localparam int SCR_W   = 640;
    localparam int SCR_H   = 480;
    localparam int FRAC    = 10;
    localparam int COORD_W = 21;

    typedef logic signed [COORD_W-1:0] coord_t;

    // Screen centre in Q11.10: 320.0 and 240.0.
    localparam coord_t CENTER_X = 21'sh050000;
    localparam coord_t CENTER_Y = 21'sh03c000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLAMP,
        ST_SCAN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/screen_raster_unshifter_coord_clamp.sv
// Combinational floor-and-clamp of one signed Q11.10 coordinate.
//   v    : Q11.10 input coordinate
//   flr  : floor(v) as a signed integer (same width as v)
//   pix  : floor(v) clamped to [0, LIMIT]
module screen_raster_unshifter_coord_clamp
    import screen_raster_unshifter_pkg::*;
#(
    parameter int LIMIT  = SCR_W - 1,
    parameter int PW     = 10,
    parameter int FRAC_B = FRAC
) (
    input  coord_t          v,
    output coord_t          flr,
    output logic [PW-1:0]   pix
);

    // Arithmetic shift floors toward minus infinity for negative values.
    assign flr = v >>> FRAC_B;

    always_comb begin
        pix = flr[PW-1:0];
        if (flr[COORD_W-1]) begin
            pix = '0;
        end else if (flr > coord_t'(LIMIT)) begin
            pix = PW'(LIMIT);
        end
    end

endmodule

// File: rtl/screen_raster_unshifter.sv
// Screen raster unshifter: clamps a Q11.10 screen-space bounding box to the
// screen, walks every covered pixel in raster order and streams the integer
// pixel coordinate plus the re-centred Q11.10 sample position over a
// valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a scan (honoured only when idle)
//   bb_xmin..bb_ymax    : inclusive box, signed Q11.10
//   out_ready           : downstream accepts the current beat
//   out_valid, out_last : beat present / final pixel of the box
//   pix_x, pix_y        : integer screen coordinate of the beat
//   cen_x, cen_y        : Q11.10 sample position relative to screen centre
//   busy, done          : scan in progress / one-cycle end-of-scan pulse
module screen_raster_unshifter
    import screen_raster_unshifter_pkg::*;
#(
    parameter int CENTER_SAMPLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [20:0] bb_xmin,
    input  logic [20:0] bb_xmax,
    input  logic [20:0] bb_ymin,
    input  logic [20:0] bb_ymax,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [20:0] cen_x,
    output logic [20:0] cen_y,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    state_t state;

    coord_t box_x0, box_x1, box_y0, box_y1;
    coord_t flr_x0, flr_x1, flr_y0, flr_y1;
    logic [9:0] xmin_c, xmax_c;
    logic [8:0] ymin_c, ymax_c;
    logic       empty;

    // (pix - half) << FRAC, plus half a pixel when sampling at the centre.
    // Done in one extra bit so the subtraction never wraps before truncation.
    function automatic coord_t centre(input logic [9:0] p, input int half);
        logic signed [COORD_W:0] t;
        t = ($signed({{(COORD_W-9){1'b0}}, p}) - (COORD_W+1)'(half)) <<< FRAC;
        if (CENTER_SAMPLE != 0) begin
            t = t + (COORD_W+1)'(1 << (FRAC-1));
        end
        return t[COORD_W-1:0];
    endfunction

    screen_raster_unshifter_coord_clamp #(.LIMIT(SCR_W-1), .PW(10)) u_clamp_x0 (
        .v(box_x0), .flr(flr_x0), .pix(xmin_c)
    );
    screen_raster_unshifter_coord_clamp #(.LIMIT(SCR_W-1), .PW(10)) u_clamp_x1 (
        .v(box_x1), .flr(flr_x1), .pix(xmax_c)
    );
    screen_raster_unshifter_coord_clamp #(.LIMIT(SCR_H-1), .PW(9)) u_clamp_y0 (
        .v(box_y0), .flr(flr_y0), .pix(ymin_c)
    );
    screen_raster_unshifter_coord_clamp #(.LIMIT(SCR_H-1), .PW(9)) u_clamp_y1 (
        .v(box_y1), .flr(flr_y1), .pix(ymax_c)
    );

    // Inverted in pixel space, or lying wholly beyond one screen edge. Once
    // neither holds, clamping cannot invert the box.
    assign empty = (flr_x0 > flr_x1) || (flr_y0 > flr_y1)
                || (flr_x0 > coord_t'(SCR_W-1)) || flr_x1[COORD_W-1]
                || (flr_y0 > coord_t'(SCR_H-1)) || flr_y1[COORD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        box_x0 <= $signed(bb_xmin);
                        box_x1 <= $signed(bb_xmax);
                        box_y0 <= $signed(bb_ymin);
                        box_y1 <= $signed(bb_ymax);
                        busy   <= 1'b1;
                        state  <= ST_CLAMP;
                    end
                end
                ST_CLAMP: begin
                    if (empty) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        pix_x     <= xmin_c;
                        pix_y     <= ymin_c;
                        out_valid <= 1'b1;
                        out_last  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else if (pix_x == xmax_c) begin
                            pix_x    <= xmin_c;
                            pix_y    <= pix_y + 9'd1;
                            out_last <= (xmin_c == xmax_c) && ((pix_y + 9'd1) == ymax_c);
                        end else begin
                            pix_x    <= pix_x + 10'd1;
                            out_last <= ((pix_x + 10'd1) == xmax_c) && (pix_y == ymax_c);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by out_valid so the centred outputs read zero outside a beat.
    assign cen_x = out_valid ? centre(pix_x, SCR_W/2) : '0;
    assign cen_y = out_valid ? centre({1'b0, pix_y}, SCR_H/2) : '0;

endmodule

// File: doc/screen_raster_unshifter.md
Name: screen_raster_unshifter

Overview:
Inverse of the vertex origin-shift stage. It takes a screen-space bounding box in the same signed Q11.10 format the shift stage emits and clamps it to the 640x480 screen. It walks every covered pixel in raster order and streams each pixel's integer screen coordinate plus its re-centred Q11.10 sample position (origin back at screen centre) to the rasteriser's edge-test stage over a valid/ready handshake.

Parameters:
SCR_W, 640, screen width in pixels
SCR_H, 480, screen height in pixels
FRAC, 10, fractional bits of the 21-bit coordinate format (320.0 = 21'h050000)
CENTER_SAMPLE, 1, 1 = add half a pixel (1<<(FRAC-1)) to the centred outputs; 0 = sample at the pixel corner

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a scan; sampled only in IDLE
bb_xmin, bb_xmax, bb_ymin, bb_ymax  in  21 each  signed Q11.10 screen-space box, inclusive
out_ready  in  1  downstream accepts the current beat
out_valid  out  1  beat available
pix_x  out  10  integer screen x
pix_y  out  9  integer screen y
cen_x, cen_y  out  21 each  signed Q11.10 centred sample position
out_last  out  1  marks the final pixel of the box
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; out_valid, out_last, busy and done = 0; pix_x, pix_y, cen_x and cen_y = 0. Reset mid-scan abandons the scan immediately, with no done pulse.
- States:
  - IDLE: start=1 -> CLAMP; latch all four box inputs; busy=1.
  - CLAMP (1 cycle): convert to pixels by floor (arithmetic >>>FRAC).
    - Clamp x to [0, SCR_W-1] and y to [0, SCR_H-1].
    - If xmin>xmax or ymin>ymax, before or after clamping (box fully off-screen or inverted) -> DONE with no beats.
    - Otherwise load x=xmin, y=ymin and go to SCAN.
  - SCAN: out_valid=1.
    - On out_valid & out_ready, advance x. When x==xmax, set x=xmin and y+1.
    - When x==xmax and y==ymax, the handshake instead goes to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency: the first out_valid is asserted 2 cycles after the start edge. At full throughput (out_ready held 1) there is one beat per cycle.
- Handshake: while out_valid=1 and out_ready=0, every out_* is held stable. out_valid never drops without a transfer except on rst.
- out_last=1 only on the beat with x==xmax and y==ymax.
- Arithmetic, evaluated combinationally from the x/y registers:
  - cen_x = ((pix_x - SCR_W/2) <<< FRAC) + (CENTER_SAMPLE ? 1<<(FRAC-1) : 0).
  - cen_y uses the same formula with SCR_H/2.
  - Compute in 22 bits, then truncate to 21. No overflow is possible in range.
- start during busy is ignored. Box inputs are don't-care outside the IDLE start cycle.
- Counter wrap: x and y never exceed the clamped max, so there is no modular wrap.

Decomposition:
- Shared package holds: SCR_W, SCR_H, FRAC, the 21-bit coordinate typedef (signed [20:0]), the screen-centre constants 21'h050000 and 21'h03c000, and the FSM state enum. The shift and unshift stages share the centre constants from here.
- One natural sub-module, coord_clamp: a combinational floor-and-clamp of a Q11.10 value to [0, limit], instantiated four times.

Test Plan:
- Reset: hold rst 2 cycles -> all outputs 0, state IDLE; start asserted during rst is ignored.
- Single-pixel box, all bounds = 21'h050000 (x) and 21'h03c000 (y), start -> one beat 2 cycles later:
  - pix=(320,240), cen_x=cen_y=21'h000200, out_last=1;
  - done pulses the cycle after the transfer.
- Clamp and edge: xmin=21'h1FFC00 (-1.0), xmax=21'h000800 (2.0), ymin=ymax=0 -> 3 beats:
  - pix_x 0, 1, 2;
  - cen_x 21'h1B0200, 21'h1B0600, 21'h1B0A00.
- Backpressure: 2x2 box at origin with out_ready toggling 1,0,0,1,... -> 4 beats in order (0,0),(1,0),(0,1),(1,1); outputs stable during stalls; out_last only on (1,1).
- Empty box: xmin=21'h0A0000 (640), xmax=21'h0B0000 -> zero beats; done 2 cycles after start; busy high exactly 2 cycles.
- Reset mid-scan: 4x4 box, rst after the 5th beat -> out_valid=0 the next cycle, no done; a new start afterwards scans correctly from (xmin,ymin).
